// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised inter-stage pipeline register for the
// five-stage MIPS datapath (D/E/M/W). Carries Instr, pc, a valid bit and NCH
// independent 32-bit payload channels, with hold (stall), flush (bubble) and
// synchronous reset.
//
// Optional build feature, macro PIPE_STAGE_PERF_EN: adds saturating
// stall_cnt / bubble_cnt performance counter outputs. With the macro
// undefined the ports and counter logic are absent.
//
// Control protocol (one edge at a time, highest priority first):
//   reset=1          -> stage returns to its reset image; EN and clr ignored.
//   clr=1            -> a bubble (nop, invalid, zero payload) is written,
//                       regardless of EN. The hazard unit stalls the upstream
//                       stage with EN=0 there and clr=1 here, so clr must
//                       win over EN=0.
//   EN=1             -> the stage captures its inputs.
//   EN=0             -> every output, including bubble_out, holds.
// There is no back-pressure path: the stage never refuses a load.

module pipe_stage_reg #(
    parameter int unsigned NCH         = 2,              // payload channels, 1..8
    parameter logic [31:0] PC_RST      = 32'h0000_3000,  // PC image after reset
    parameter bit          CLR_KEEP_PC = 1'b1            // bubble keeps incoming PC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                EN,
    input  logic                clr,
    input  logic [31:0]         Instr,
    input  logic [31:0]         pc,
    input  logic                valid_in,
    input  logic [32*NCH-1:0]   data_in,
    output logic [31:0]         Instr_out,
    output logic [31:0]         pc_out,
    output logic                valid_out,
    output logic [32*NCH-1:0]   data_out,
    output logic                bubble_out
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         bubble_cnt
`endif
);

    // Per-edge action, decoded once so every register group agrees on it.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_RESET = 2'd3
    } action_t;

    action_t action;

    // A bubble's PC: either traced through for EPC, or parked at the reset PC.
    logic [31:0] bubble_pc;

    // Next-state images of the scalar fields.
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        bubble_d;

    // Payload storage, one register per channel; channels never interact.
    logic [31:0] ch_q [NCH];

    assign bubble_pc = CLR_KEEP_PC ? pc : PC_RST;

    // Decode the edge's action with priority reset > clr > EN > hold.
    always_comb begin
        action = ACT_HOLD;
        if (reset) begin
            action = ACT_RESET;
        end else if (clr) begin
            action = ACT_FLUSH;
        end else if (EN) begin
            action = ACT_LOAD;
        end
    end

    // Compute the next value of the scalar fields from the decoded action.
    always_comb begin
        instr_d  = Instr_out;
        pc_d     = pc_out;
        valid_d  = valid_out;
        bubble_d = bubble_out;
        case (action)
            ACT_RESET: begin
                instr_d  = 32'h0000_0000;
                pc_d     = PC_RST;
                valid_d  = 1'b0;
                bubble_d = 1'b0;
            end
            ACT_FLUSH: begin
                // Instr=0 is sll $0,$0,0, i.e. a nop; valid is dropped so
                // downstream never mistakes the bubble for a real nop.
                instr_d  = 32'h0000_0000;
                pc_d     = bubble_pc;
                valid_d  = 1'b0;
                bubble_d = 1'b1;
            end
            ACT_LOAD: begin
                // valid follows valid_in only; an all-zero Instr with
                // valid_in=1 is a genuine nop and not a bubble.
                instr_d  = Instr;
                pc_d     = pc;
                valid_d  = valid_in;
                bubble_d = 1'b0;
            end
            default: begin
                // ACT_HOLD: keep everything, a held bubble stays a bubble.
            end
        endcase
    end

    // Scalar field registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            Instr_out  <= 32'h0000_0000;
            pc_out     <= PC_RST;
            valid_out  <= 1'b0;
            bubble_out <= 1'b0;
        end else begin
            Instr_out  <= instr_d;
            pc_out     <= pc_d;
            valid_out  <= valid_d;
            bubble_out <= bubble_d;
        end
    end

    // Payload channel registers: cleared on reset or flush, loaded on EN.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                ch_q[k] <= 32'h0000_0000;
            end
        end else begin
            case (action)
                ACT_FLUSH: begin
                    for (int k = 0; k < NCH; k++) begin
                        ch_q[k] <= 32'h0000_0000;
                    end
                end
                ACT_LOAD: begin
                    for (int k = 0; k < NCH; k++) begin
                        ch_q[k] <= data_in[32*k +: 32];
                    end
                end
                default: begin
                    // Hold; ACT_RESET cannot occur in this branch.
                end
            endcase
        end
    end

    // Repack the channel registers onto the flat output bus, channel k at
    // bits [32k+31:32k].
    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign data_out[32*g +: 32] = ch_q[g];
    end

`ifdef PIPE_STAGE_PERF_EN
    // Count held edges (stalls of this stage); saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'h0000_0000;
        end else if (action == ACT_HOLD && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Count flush edges (bubbles inserted); saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= 32'h0000_0000;
        end else if (action == ACT_FLUSH && bubble_cnt != 32'hFFFF_FFFF) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- self-checking bench for pipe_stage_reg. Three
// instances share clock and control: NCH=2/keep-PC, NCH=8/clear-PC and
// NCH=1/keep-PC. A behavioural model of the stage contents is advanced on
// every rising edge and compared against the outputs #1 later.
// Build with +define+PIPE_STAGE_PERF_EN to also check the counters.

module tb_pipe_stage_reg;

  localparam logic [31:0] PC_RST = 32'h0000_3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         en;
  logic         clr;
  logic [31:0]  instr;
  logic [31:0]  pc;
  logic         valid_in;
  logic [63:0]  data2;
  logic [255:0] data8;
  logic [31:0]  data1;

  logic [31:0]  instr_o2, pc_o2, instr_o8, pc_o8, instr_o1, pc_o1;
  logic         valid_o2, valid_o8, valid_o1;
  logic         bub_o2, bub_o8, bub_o1;
  logic [63:0]  data_o2;
  logic [255:0] data_o8;
  logic [31:0]  data_o1;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stall_o2, bcnt_o2, stall_o8, bcnt_o8, stall_o1, bcnt_o1;
`endif

  pipe_stage_reg #(.NCH(2), .PC_RST(PC_RST), .CLR_KEEP_PC(1'b1)) u_dut (
    .clk(clk), .reset(reset), .EN(en), .clr(clr), .Instr(instr), .pc(pc),
    .valid_in(valid_in), .data_in(data2), .Instr_out(instr_o2), .pc_out(pc_o2),
    .valid_out(valid_o2), .data_out(data_o2), .bubble_out(bub_o2)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_o2), .bubble_cnt(bcnt_o2)
`endif
  );

  pipe_stage_reg #(.NCH(8), .PC_RST(PC_RST), .CLR_KEEP_PC(1'b0)) u_dut8 (
    .clk(clk), .reset(reset), .EN(en), .clr(clr), .Instr(instr), .pc(pc),
    .valid_in(valid_in), .data_in(data8), .Instr_out(instr_o8), .pc_out(pc_o8),
    .valid_out(valid_o8), .data_out(data_o8), .bubble_out(bub_o8)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_o8), .bubble_cnt(bcnt_o8)
`endif
  );

  pipe_stage_reg #(.NCH(1), .PC_RST(PC_RST), .CLR_KEEP_PC(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .EN(en), .clr(clr), .Instr(instr), .pc(pc),
    .valid_in(valid_in), .data_in(data1), .Instr_out(instr_o1), .pc_out(pc_o1),
    .valid_out(valid_o1), .data_out(data_o1), .bubble_out(bub_o1)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_o1), .bubble_cnt(bcnt_o1)
`endif
  );

  // ---------------- reference model ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  m_instr, m_pc2, m_pc8, m_pc1;
  logic         m_valid, m_bubble;
  logic [63:0]  m_d2;
  logic [255:0] m_d8;
  logic [31:0]  m_d1;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  m_stall, m_bcnt;
`endif

  // Advance one rising edge, update the model from the stage rules, then
  // settle #1 so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_instr = 0; m_valid = 0; m_bubble = 0;
      m_pc2 = PC_RST; m_pc8 = PC_RST; m_pc1 = PC_RST;
      m_d2 = 0; m_d8 = 0; m_d1 = 0;
`ifdef PIPE_STAGE_PERF_EN
      m_stall = 0; m_bcnt = 0;
`endif
    end else if (clr) begin
      m_instr = 0; m_valid = 0; m_bubble = 1;
      m_pc2 = pc; m_pc8 = PC_RST; m_pc1 = pc;
      m_d2 = 0; m_d8 = 0; m_d1 = 0;
`ifdef PIPE_STAGE_PERF_EN
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
`endif
    end else if (en) begin
      m_instr = instr; m_valid = valid_in; m_bubble = 0;
      m_pc2 = pc; m_pc8 = pc; m_pc1 = pc;
      m_d2 = data2; m_d8 = data8; m_d1 = data1;
    end else begin
`ifdef PIPE_STAGE_PERF_EN
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_inputs();
    instr    = $urandom;
    pc       = $urandom;
    valid_in = 1'($urandom_range(0, 1));
    data2    = {$urandom, $urandom};
    for (int k = 0; k < 8; k++) data8[32*k +: 32] = $urandom;
    data1    = $urandom;
  endtask

  task automatic test_reset();
    reset = 1; en = 1; clr = 1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      tick();
    end
    n_cmp++; if (instr_o2 !== 32'h0) begin n_err++; $display("FAIL reset_instr got=%h exp=%h", instr_o2, 32'h0); end
    n_cmp++; if (pc_o2 !== 32'h3000) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc_o2, 32'h3000); end
    n_cmp++; if (valid_o2 !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid_o2); end
    n_cmp++; if (data_o2 !== 64'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", data_o2); end
    n_cmp++; if (bub_o2 !== 1'b0) begin n_err++; $display("FAIL reset_bubble got=%b exp=0", bub_o2); end
    n_cmp++; if (pc_o8 !== 32'h3000) begin n_err++; $display("FAIL reset_pc8 got=%h exp=%h", pc_o8, 32'h3000); end
    n_cmp++; if (data_o8 !== 256'h0) begin n_err++; $display("FAIL reset_data8 got=%h exp=0", data_o8); end
    n_cmp++; if (data_o1 !== 32'h0) begin n_err++; $display("FAIL reset_data1 got=%h exp=0", data_o1); end
`ifdef PIPE_STAGE_PERF_EN
    n_cmp++; if (stall_o2 !== 32'h0) begin n_err++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_o2); end
    n_cmp++; if (bcnt_o2 !== 32'h0) begin n_err++; $display("FAIL reset_bubble_cnt got=%0d exp=0", bcnt_o2); end
`endif
    reset = 0; clr = 0;
  endtask

  task automatic test_load();
    rand_inputs();
    en = 1; clr = 0; instr = 32'h2408_0005; pc = 32'h3004; valid_in = 1;
    data2 = {32'hAAAA_5555, 32'h1234_5678};
    tick();
    n_cmp++; if (instr_o2 !== 32'h2408_0005) begin n_err++; $display("FAIL load_instr got=%h exp=%h", instr_o2, 32'h2408_0005); end
    n_cmp++; if (pc_o2 !== 32'h3004) begin n_err++; $display("FAIL load_pc got=%h exp=%h", pc_o2, 32'h3004); end
    n_cmp++; if (valid_o2 !== 1'b1) begin n_err++; $display("FAIL load_valid got=%b exp=1", valid_o2); end
    n_cmp++; if (data_o2 !== 64'hAAAA_5555_1234_5678) begin n_err++; $display("FAIL load_data got=%h exp=%h", data_o2, 64'hAAAA_5555_1234_5678); end
    n_cmp++; if (bub_o2 !== 1'b0) begin n_err++; $display("FAIL load_bubble got=%b exp=0", bub_o2); end
    n_cmp++; if (data_o8 !== m_d8) begin n_err++; $display("FAIL load_data8 got=%h exp=%h", data_o8, m_d8); end
  endtask

  task automatic test_stall();
    en = 0; clr = 0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
      n_cmp++; if (instr_o2 !== 32'h2408_0005) begin n_err++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, instr_o2, 32'h2408_0005); end
      n_cmp++; if (pc_o2 !== 32'h3004) begin n_err++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc_o2, 32'h3004); end
      n_cmp++; if (valid_o2 !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, valid_o2); end
      n_cmp++; if (data_o2 !== 64'hAAAA_5555_1234_5678) begin n_err++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, data_o2, 64'hAAAA_5555_1234_5678); end
      n_cmp++; if (data_o8 !== m_d8) begin n_err++; $display("FAIL stall_data8[%0d] got=%h exp=%h", i, data_o8, m_d8); end
    end
`ifdef PIPE_STAGE_PERF_EN
    n_cmp++; if (stall_o2 !== 32'd3) begin n_err++; $display("FAIL stall_cnt got=%0d exp=3", stall_o2); end
`endif
  endtask

  task automatic test_flush_over_stall();
    rand_inputs();
    en = 0; clr = 1; pc = 32'h3010;
    tick();
    n_cmp++; if (instr_o2 !== 32'h0) begin n_err++; $display("FAIL flush_instr got=%h exp=0", instr_o2); end
    n_cmp++; if (valid_o2 !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", valid_o2); end
    n_cmp++; if (data_o2 !== 64'h0) begin n_err++; $display("FAIL flush_data got=%h exp=0", data_o2); end
    n_cmp++; if (bub_o2 !== 1'b1) begin n_err++; $display("FAIL flush_bubble got=%b exp=1", bub_o2); end
    n_cmp++; if (pc_o2 !== 32'h3010) begin n_err++; $display("FAIL flush_pc_keep got=%h exp=%h", pc_o2, 32'h3010); end
    n_cmp++; if (pc_o8 !== 32'h3000) begin n_err++; $display("FAIL flush_pc_clear got=%h exp=%h", pc_o8, 32'h3000); end
    n_cmp++; if (data_o8 !== 256'h0) begin n_err++; $display("FAIL flush_data8 got=%h exp=0", data_o8); end
    rand_inputs();
    en = 0; clr = 0;
    tick();
    n_cmp++; if (bub_o2 !== 1'b1) begin n_err++; $display("FAIL held_bubble got=%b exp=1", bub_o2); end
    n_cmp++; if (bub_o8 !== 1'b1) begin n_err++; $display("FAIL held_bubble8 got=%b exp=1", bub_o8); end
    n_cmp++; if (pc_o2 !== 32'h3010) begin n_err++; $display("FAIL held_bubble_pc got=%h exp=%h", pc_o2, 32'h3010); end
    n_cmp++; if (valid_o2 !== 1'b0) begin n_err++; $display("FAIL held_bubble_valid got=%b exp=0", valid_o2); end
`ifdef PIPE_STAGE_PERF_EN
    n_cmp++; if (bcnt_o2 !== 32'd1) begin n_err++; $display("FAIL bubble_cnt got=%0d exp=1", bcnt_o2); end
    n_cmp++; if (stall_o2 !== 32'd4) begin n_err++; $display("FAIL stall_cnt_after got=%0d exp=4", stall_o2); end
`endif
  endtask

  task automatic test_real_nop();
    rand_inputs();
    en = 1; clr = 0; instr = 32'h0; valid_in = 1;
    tick();
    n_cmp++; if (instr_o2 !== 32'h0) begin n_err++; $display("FAIL nop_instr got=%h exp=0", instr_o2); end
    n_cmp++; if (valid_o2 !== 1'b1) begin n_err++; $display("FAIL nop_valid got=%b exp=1", valid_o2); end
    n_cmp++; if (bub_o2 !== 1'b0) begin n_err++; $display("FAIL nop_bubble got=%b exp=0", bub_o2); end
    n_cmp++; if (pc_o8 !== pc) begin n_err++; $display("FAIL nop_pc8 got=%h exp=%h", pc_o8, pc); end
  endtask

  task automatic test_walking_one();
    int bits [3] = '{0, 13, 31};
    logic [255:0] e8;
    logic [63:0]  e2;
    logic [31:0]  e1;
    en = 1; clr = 0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        e8 = 256'h1 << (32*k + bits[j]);
        e2 = 64'h1 << (32*(k % 2) + bits[j]);
        e1 = 32'h1 << ((bits[j] + k) % 32);
        data8 = 0; data8[32*k + bits[j]] = 1'b1;
        data2 = 0; data2[32*(k % 2) + bits[j]] = 1'b1;
        data1 = 0; data1[(bits[j] + k) % 32] = 1'b1;
        tick();
        n_cmp++; if (data_o8 !== e8) begin n_err++; $display("FAIL walk8 ch%0d b%0d got=%h exp=%h", k, bits[j], data_o8, e8); end
        n_cmp++; if (data_o2 !== e2) begin n_err++; $display("FAIL walk2 ch%0d b%0d got=%h exp=%h", k % 2, bits[j], data_o2, e2); end
        n_cmp++; if (data_o1 !== e1) begin n_err++; $display("FAIL walk1 b%0d got=%h exp=%h", (bits[j] + k) % 32, data_o1, e1); end
      end
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf_saturation();
    reset = 0; en = 0; clr = 0;
    force u_dut.bubble_cnt = 32'hFFFF_FFFE;
    #1;
    release u_dut.bubble_cnt;
    m_bcnt = 32'hFFFF_FFFE;
    clr = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
    end
    n_cmp++; if (bcnt_o2 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL bubble_cnt_sat got=%h exp=%h", bcnt_o2, 32'hFFFF_FFFF); end
    clr = 0;
    // The other instances were not forced; keep the model in step with u_dut only.
    reset = 1; tick(); reset = 0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 19) == 0);
      en    = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++; if (instr_o2 !== m_instr) begin n_err++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", i, instr_o2, m_instr); end
      n_cmp++; if (pc_o2 !== m_pc2) begin n_err++; $display("FAIL rnd_pc2[%0d] got=%h exp=%h", i, pc_o2, m_pc2); end
      n_cmp++; if (pc_o8 !== m_pc8) begin n_err++; $display("FAIL rnd_pc8[%0d] got=%h exp=%h", i, pc_o8, m_pc8); end
      n_cmp++; if (pc_o1 !== m_pc1) begin n_err++; $display("FAIL rnd_pc1[%0d] got=%h exp=%h", i, pc_o1, m_pc1); end
      n_cmp++; if (valid_o2 !== m_valid || valid_o8 !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got=%b/%b exp=%b", i, valid_o2, valid_o8, m_valid); end
      n_cmp++; if (bub_o2 !== m_bubble || bub_o1 !== m_bubble) begin n_err++; $display("FAIL rnd_bubble[%0d] got=%b/%b exp=%b", i, bub_o2, bub_o1, m_bubble); end
      n_cmp++; if (data_o2 !== m_d2) begin n_err++; $display("FAIL rnd_data2[%0d] got=%h exp=%h", i, data_o2, m_d2); end
      n_cmp++; if (data_o8 !== m_d8) begin n_err++; $display("FAIL rnd_data8[%0d] got=%h exp=%h", i, data_o8, m_d8); end
      n_cmp++; if (data_o1 !== m_d1 || instr_o1 !== m_instr) begin n_err++; $display("FAIL rnd_dut1[%0d] got=%h/%h exp=%h/%h", i, data_o1, instr_o1, m_d1, m_instr); end
`ifdef PIPE_STAGE_PERF_EN
      n_cmp++; if (stall_o2 !== m_stall) begin n_err++; $display("FAIL rnd_stall_cnt[%0d] got=%0d exp=%0d", i, stall_o2, m_stall); end
      n_cmp++; if (bcnt_o2 !== m_bcnt) begin n_err++; $display("FAIL rnd_bubble_cnt[%0d] got=%0d exp=%0d", i, bcnt_o2, m_bcnt); end
`endif
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset = 1; en = 0; clr = 0;
    rand_inputs();
    test_reset();
    test_load();
    test_stall();
    test_flush_over_stall();
    test_real_nop();
    test_walking_one();
`ifdef PIPE_STAGE_PERF_EN
    test_perf_saturation();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
